// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional baud-rate generator with oversample tick and bit pulse
// Optional feature macro: BAUD_RX_MIDPOINT_EN (adds rx_sync / rx_sample mid-bit sampling)
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   enable     : 1 = run, 0 = freeze counters
//   load       : single-cycle restart, overrides enable
//   baud_val   : integer divisor, oversample period = baud_val+1 cycles
//   baud_frac  : fractional period extension in 1/2^FRAC_WIDTH cycle units
//   baud_tick  : registered one-cycle oversample pulse
//   xmit_pulse : registered pulse on every OVERSAMPLE-th baud_tick
//   bit_phase  : baud_ticks elapsed within the current bit
//   rx_sync    : (macro) start-bit edge from RX logic, realigns rx phase
//   rx_sample  : (macro) registered mid-bit sample strobe
module baud_gen_frac #(
  parameter int CNT_WIDTH  = 13,
  parameter int FRAC_WIDTH = 3,
  parameter int OVERSAMPLE = 16,
  localparam int PH_W      = $clog2(OVERSAMPLE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [CNT_WIDTH-1:0]  baud_val,
  input  logic [FRAC_WIDTH-1:0] baud_frac,
  output logic                  baud_tick,
  output logic                  xmit_pulse,
  output logic [PH_W-1:0]       bit_phase
`ifdef BAUD_RX_MIDPOINT_EN
  ,
  input  logic                  rx_sync,
  output logic                  rx_sample
`endif
);

  localparam int CW1 = CNT_WIDTH + 1;

  // One extra bit so baud_val all-ones plus an accumulator carry still fits.
  logic [CW1-1:0]        cnt_q, cnt_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic                  baud_tick_q, baud_tick_d;
  logic                  xmit_pulse_q, xmit_pulse_d;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  reload;

  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    phase_d      = phase_q;
    baud_tick_d  = 1'b0;
    xmit_pulse_d = 1'b0;
    acc_sum      = {1'b0, acc_q} + {1'b0, baud_frac};
    reload       = 1'b0;
    if (load) begin
      cnt_d   = {1'b0, baud_val};
      acc_d   = '0;
      phase_d = '0;
    end else if (enable) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW1'(1);
      end else begin
        reload = 1'b1;
        // Accumulator overflow stretches this period by one cycle, which
        // spreads the fractional extension evenly across the bit.
        acc_d        = acc_sum[FRAC_WIDTH-1:0];
        cnt_d        = {1'b0, baud_val} + CW1'(acc_sum[FRAC_WIDTH]);
        baud_tick_d  = 1'b1;
        xmit_pulse_d = (phase_q == PH_W'(OVERSAMPLE - 1));
        phase_d      = phase_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      phase_q      <= '0;
      baud_tick_q  <= 1'b0;
      xmit_pulse_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      phase_q      <= phase_d;
      baud_tick_q  <= baud_tick_d;
      xmit_pulse_q <= xmit_pulse_d;
    end
  end

  assign baud_tick  = baud_tick_q;
  assign xmit_pulse = xmit_pulse_q;
  assign bit_phase  = phase_q;

`ifdef BAUD_RX_MIDPOINT_EN
  logic [PH_W-1:0] rx_phase_q, rx_phase_d;
  logic            rx_sample_q, rx_sample_d;

  // rx_sync realigns the receive phase to the start-bit edge; it beats a
  // coincident reload so a fresh alignment never emits a stale sample.
  always_comb begin
    rx_phase_d  = rx_phase_q;
    rx_sample_d = 1'b0;
    if (load || rx_sync) begin
      rx_phase_d = '0;
    end else if (reload) begin
      rx_sample_d = (rx_phase_q == PH_W'(OVERSAMPLE / 2 - 1));
      rx_phase_d  = rx_phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_phase_q  <= '0;
      rx_sample_q <= 1'b0;
    end else begin
      rx_phase_q  <= rx_phase_d;
      rx_sample_q <= rx_sample_d;
    end
  end

  assign rx_sample = rx_sample_q;
`endif

endmodule
